// File: rtl/ram_tdp_be_clr.sv
// True dual-port RAM with byte-lane write enables, configurable read latency and
// read-during-write behaviour, and a whole-array clear engine that also runs out of reset.
module ram_tdp_be_clr #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       DEPTH      = 256,
    parameter int unsigned       BYTE_W     = 8,
    parameter int unsigned       RD_LATENCY = 1,
    parameter int unsigned       RDW_MODE   = 0,
    parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
    localparam int unsigned      ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned      NB         = WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  ena,
    input  logic                  enb,
    input  logic [NB-1:0]         wea,
    input  logic [NB-1:0]         web,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [WIDTH-1:0]      dia,
    input  logic [WIDTH-1:0]      dib,
    output logic [WIDTH-1:0]      doa,
    output logic [WIDTH-1:0]      dob,
    output logic                  doa_valid,
    output logic                  dob_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Port signals gathered as index 0 = A, 1 = B
    logic [1:0]                 en_v;
    logic [1:0][NB-1:0]         we_v;
    logic [1:0][ADDR_WIDTH-1:0] addr_v;
    logic [1:0][WIDTH-1:0]      di_v;

    logic [1:0]            acc_c, inr_c, rv_c, sv_c;
    logic [1:0][WIDTH-1:0] old_c, rd_c, sd_c;

    logic [1:0]            dv_q;
    logic [1:0][WIDTH-1:0] do_q;

    assign en_v   = {enb, ena};
    assign we_v   = {web, wea};
    assign addr_v = {addrb, addra};
    assign di_v   = {dib, dia};

    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                     input logic [WIDTH-1:0] new_w,
                                                     input logic [NB-1:0]    we);
        merge_lanes = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) merge_lanes[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
        end
    endfunction

    // Clear engine state register; reset lands in CLEAR so the array is initialised on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_DONE;
                    clr_addr_d = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign clr_busy = busy_q;
    assign clr_done = done_q;

    // Per-port access decode and the word presented to the read pipeline
    always_comb begin
        acc_c = '0;
        inr_c = '0;
        rv_c  = '0;
        old_c = '0;
        rd_c  = '0;
        for (int p = 0; p < 2; p++) begin
            acc_c[p] = en_v[p] & ~busy_q;
            inr_c[p] = (32'(addr_v[p]) < DEPTH);
            old_c[p] = inr_c[p] ? mem_q[addr_v[p]] : '0;
            if (!acc_c[p])             rv_c[p] = 1'b0;
            else if (we_v[p] == '0)    rv_c[p] = 1'b1;
            else                       rv_c[p] = (RDW_MODE != 2);
            rd_c[p] = old_c[p];
            if (RDW_MODE == 1 && we_v[p] != '0 && inr_c[p]) begin
                rd_c[p] = merge_lanes(old_c[p], di_v[p], we_v[p]);
            end
        end
    end

    // Port B is applied first so port A wins on lanes both ports enable
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= INIT_VALUE;
        end else begin
            for (int p = 1; p >= 0; p--) begin
                if (acc_c[p] && inr_c[p]) begin
                    for (int i = 0; i < NB; i++) begin
                        if (we_v[p][i]) begin
                            mem_q[addr_v[p]][i*BYTE_W +: BYTE_W] <= di_v[p][i*BYTE_W +: BYTE_W];
                        end
                    end
                end
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [1:0]            pv_q;
            logic [1:0][WIDTH-1:0] pd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv_q <= '0;
                    pd_q <= '0;
                end else begin
                    pv_q <= rv_c;
                    for (int p = 0; p < 2; p++) begin
                        if (rv_c[p]) pd_q[p] <= rd_c[p];
                    end
                end
            end

            assign sv_c = pv_q;
            assign sd_c = pd_q;
        end else begin : g_lat1
            assign sv_c = rv_c;
            assign sd_c = rd_c;
        end
    endgenerate

    // Output register holds the last valid word between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q <= '0;
            do_q <= '0;
        end else begin
            dv_q <= sv_c;
            for (int p = 0; p < 2; p++) begin
                if (sv_c[p]) do_q[p] <= sd_c[p];
            end
        end
    end

    assign doa       = do_q[0];
    assign dob       = do_q[1];
    assign doa_valid = dv_q[0];
    assign dob_valid = dv_q[1];

endmodule

// File: tb/tb_ram_tdp_be_clr.sv
// Directed bench for ram_tdp_be_clr: three instances cover read latency 1/2,
// the three read-during-write modes, a non-power-of-2 depth and the clear engine.
module tb_ram_tdp_be_clr;

    localparam int unsigned W  = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n     [3];
    logic          clr_req   [3];
    logic          clr_busy  [3];
    logic          clr_done  [3];
    logic          ena       [3];
    logic          enb       [3];
    logic [NB-1:0] wea       [3];
    logic [NB-1:0] web       [3];
    logic [AW-1:0] addra     [3];
    logic [AW-1:0] addrb     [3];
    logic [W-1:0]  dia       [3];
    logic [W-1:0]  dib       [3];
    logic [W-1:0]  doa       [3];
    logic [W-1:0]  dob       [3];
    logic          doa_valid [3];
    logic          dob_valid [3];

    int n_checks = 0;
    int n_errs   = 0;
    int nb [3];
    int nd [3];
    logic [W-1:0] wd [4];

    // u0: latency 1, read-first, depth 256
    ram_tdp_be_clr #(.WIDTH(32), .DEPTH(256), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(0),
                     .INIT_VALUE(32'hC1EA_C1EA)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .clr_req(clr_req[0]), .clr_busy(clr_busy[0]),
        .clr_done(clr_done[0]), .ena(ena[0]), .enb(enb[0]), .wea(wea[0]), .web(web[0]),
        .addra(addra[0]), .addrb(addrb[0]), .dia(dia[0]), .dib(dib[0]), .doa(doa[0]),
        .dob(dob[0]), .doa_valid(doa_valid[0]), .dob_valid(dob_valid[0]));

    // u1: latency 2, write-first, depth 200
    ram_tdp_be_clr #(.WIDTH(32), .DEPTH(200), .BYTE_W(8), .RD_LATENCY(2), .RDW_MODE(1),
                     .INIT_VALUE(32'hDEAD_BEEF)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .clr_req(clr_req[1]), .clr_busy(clr_busy[1]),
        .clr_done(clr_done[1]), .ena(ena[1]), .enb(enb[1]), .wea(wea[1]), .web(web[1]),
        .addra(addra[1]), .addrb(addrb[1]), .dia(dia[1]), .dib(dib[1]), .doa(doa[1]),
        .dob(dob[1]), .doa_valid(doa_valid[1]), .dob_valid(dob_valid[1]));

    // u2: latency 1, no-change, depth 256
    ram_tdp_be_clr #(.WIDTH(32), .DEPTH(256), .BYTE_W(8), .RD_LATENCY(1), .RDW_MODE(2),
                     .INIT_VALUE(32'h0)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .clr_req(clr_req[2]), .clr_busy(clr_busy[2]),
        .clr_done(clr_done[2]), .ena(ena[2]), .enb(enb[2]), .wea(wea[2]), .web(web[2]),
        .addra(addra[2]), .addrb(addrb[2]), .dia(dia[2]), .dib(dib[2]), .doa(doa[2]),
        .dob(dob[2]), .doa_valid(doa_valid[2]), .dob_valid(dob_valid[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic op_a(input int k, input logic [NB-1:0] we, input logic [AW-1:0] addr,
                        input logic [W-1:0] d);
        ena[k] = 1'b1; wea[k] = we; addra[k] = addr; dia[k] = d;
        @(negedge clk);
        ena[k] = 1'b0; wea[k] = '0;
    endtask

    task automatic op_b(input int k, input logic [NB-1:0] we, input logic [AW-1:0] addr,
                        input logic [W-1:0] d);
        enb[k] = 1'b1; web[k] = we; addrb[k] = addr; dib[k] = d;
        @(negedge clk);
        enb[k] = 1'b0; web[k] = '0;
    endtask

    // Counts busy/done cycles on every instance until all are idle; poke fires a stray clr_req on u0
    task automatic count_clear(input bit poke);
        for (int k = 0; k < 3; k++) begin
            nb[k] = 0;
            nd[k] = 0;
        end
        for (int i = 0; i < 1000; i++) begin
            if (!clr_busy[0] && !clr_busy[1] && !clr_busy[2]) break;
            for (int k = 0; k < 3; k++) begin
                if (clr_busy[k]) nb[k]++;
                if (clr_done[k]) nd[k]++;
            end
            if (poke) clr_req[0] = (i == 50);
            @(negedge clk);
        end
        clr_req[0] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; clr_req[k] = 1'b0; ena[k] = 1'b0; enb[k] = 1'b0;
            wea[k] = '0; web[k] = '0; addra[k] = '0; addrb[k] = '0; dia[k] = '0; dib[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(clr_busy[0]), 32'd1);
        check("rst_done", 32'(clr_done[0]), 32'd0);
        check("rst_doa", doa[0], 32'h0);
        check("rst_doa_valid", 32'(doa_valid[0]), 32'd0);
        check("rst_dob_valid", 32'(dob_valid[0]), 32'd0);

        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        count_clear(1'b0);
        check("boot_busy_u0", 32'(nb[0]), 32'd257);
        check("boot_done_u0", 32'(nd[0]), 32'd1);
        check("boot_busy_u1", 32'(nb[1]), 32'd201);
        check("boot_busy_u2", 32'(nb[2]), 32'd257);

        // Array initialised by the clear engine
        op_a(0, 4'h0, 8'h80, 32'h0);
        check("init_rd_u0", doa[0], 32'hC1EA_C1EA);
        check("init_rd_u0_valid", 32'(doa_valid[0]), 32'd1);
        @(negedge clk);
        check("valid_one_cycle", 32'(doa_valid[0]), 32'd0);
        op_a(1, 4'h0, 8'h80, 32'h0);
        check("lat2_not_yet", 32'(doa_valid[1]), 32'd0);
        @(negedge clk);
        check("init_rd_u1", doa[1], 32'hDEAD_BEEF);
        check("init_rd_u1_valid", 32'(doa_valid[1]), 32'd1);

        // Byte-lane partial write; read-first returns the pre-write word
        op_a(0, 4'hF, 8'd5, 32'hAABB_CCDD);
        op_a(0, 4'b0010, 8'd5, 32'h1122_3344);
        check("rdw0_prewrite", doa[0], 32'hAABB_CCDD);
        op_a(0, 4'h0, 8'd5, 32'h0);
        check("lane_merge", doa[0], 32'hAABB_33DD);

        op_a(0, 4'hF, 8'd9, 32'h33);
        op_a(0, 4'hF, 8'd9, 32'h55);
        check("rdw0_old", doa[0], 32'h33);
        check("rdw0_valid", 32'(doa_valid[0]), 32'd1);

        // Write-first on latency-2 instance
        op_a(1, 4'hF, 8'd9, 32'h33);
        op_a(1, 4'hF, 8'd9, 32'h55);
        check("rdw1_first", doa[1], 32'h33);
        @(negedge clk);
        check("rdw1_new", doa[1], 32'h55);
        check("rdw1_valid", 32'(doa_valid[1]), 32'd1);

        // No-change mode
        op_a(2, 4'hF, 8'd9, 32'h33);
        check("rdw2_nv", 32'(doa_valid[2]), 32'd0);
        check("rdw2_hold0", doa[2], 32'h0);
        op_a(2, 4'h0, 8'd9, 32'h0);
        check("rdw2_rd33", doa[2], 32'h33);
        op_a(2, 4'hF, 8'd9, 32'h55);
        check("rdw2_nv2", 32'(doa_valid[2]), 32'd0);
        check("rdw2_hold33", doa[2], 32'h33);
        op_a(2, 4'h0, 8'd9, 32'h0);
        check("rdw2_rd55", doa[2], 32'h55);

        // Back-to-back reads at latency 2
        wd[0] = 32'h0; wd[1] = 32'hA1A1_0001; wd[2] = 32'hB2B2_0002; wd[3] = 32'hC3C3_0003;
        for (int i = 1; i < 4; i++) op_a(1, 4'hF, AW'(i), wd[i]);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                ena[1] = 1'b1; wea[1] = '0; addra[1] = AW'(i + 1);
            end else begin
                ena[1] = 1'b0;
            end
            @(negedge clk);
            check("b2b_valid", 32'(doa_valid[1]), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 3) check("b2b_data", doa[1], wd[i]);
        end

        // Out-of-range address on depth-200 instance
        op_a(1, 4'hF, 8'd210, 32'h1234_5678);
        op_a(1, 4'h0, 8'd210, 32'h0);
        @(negedge clk);
        check("oor_rd", doa[1], 32'h0);
        check("oor_valid", 32'(doa_valid[1]), 32'd1);

        // Cross-port read sees the pre-write word
        op_a(0, 4'hF, 8'd8, 32'h0102_0304);
        ena[0] = 1'b1; wea[0] = 4'hF; addra[0] = 8'd8; dia[0] = 32'hFFFF_FFFF;
        enb[0] = 1'b1; web[0] = 4'h0; addrb[0] = 8'd8;
        @(negedge clk);
        ena[0] = 1'b0; wea[0] = '0; enb[0] = 1'b0;
        check("xport_old", dob[0], 32'h0102_0304);
        op_b(0, 4'h0, 8'd8, 32'h0);
        check("xport_new", dob[0], 32'hFFFF_FFFF);

        // Dual write to the same address: A wins overlapping lanes
        ena[0] = 1'b1; wea[0] = 4'b0011; addra[0] = 8'd7; dia[0] = 32'h0000_00AA;
        enb[0] = 1'b1; web[0] = 4'b1111; addrb[0] = 8'd7; dib[0] = 32'h1234_5678;
        @(negedge clk);
        ena[0] = 1'b0; wea[0] = '0; enb[0] = 1'b0; web[0] = '0;
        op_a(0, 4'h0, 8'd7, 32'h0);
        check("dual_wr", doa[0], 32'h1234_00AA);

        // Software clear with a masked read, then reset mid-clear at address 100
        clr_req[0] = 1'b1;
        @(negedge clk);
        clr_req[0] = 1'b0;
        check("clr_busy", 32'(clr_busy[0]), 32'd1);
        @(negedge clk);
        op_a(0, 4'h0, 8'd5, 32'h0);
        check("clr_masked", 32'(doa_valid[0]), 32'd0);
        repeat (98) @(negedge clk);
        rst_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(clr_busy[0]), 32'd1);
        check("midrst_done", 32'(clr_done[0]), 32'd0);
        rst_n[0] = 1'b1;
        count_clear(1'b1);
        check("restart_busy", 32'(nb[0]), 32'd257);
        check("restart_done", 32'(nd[0]), 32'd1);
        op_a(0, 4'h0, 8'd5, 32'h0);
        check("cleared_rd", doa[0], 32'hC1EA_C1EA);

        // Read in flight when clear starts still completes
        ena[1] = 1'b1; wea[1] = '0; addra[1] = 8'd1; clr_req[1] = 1'b1;
        @(negedge clk);
        ena[1] = 1'b0; clr_req[1] = 1'b0;
        check("inflight_busy", 32'(clr_busy[1]), 32'd1);
        check("inflight_stage", 32'(doa_valid[1]), 32'd0);
        @(negedge clk);
        check("inflight_valid", 32'(doa_valid[1]), 32'd1);
        check("inflight_data", doa[1], wd[1]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
